// File: rtl/debouncer_bank.sv
// Multi-channel switch conditioner: per-channel synchroniser, stability-counter debounce,
// registered level plus one-cycle rise/fall pulses.
module debouncer_bank #(
  parameter int unsigned         CHANNELS       = 4,
  parameter int unsigned         STABLE_SAMPLES = 12500,
  parameter int unsigned         SYNC_STAGES    = 2,
  parameter logic [CHANNELS-1:0] RESET_LEVEL    = '0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] in,
  input  logic                sample_en,
  output logic [CHANNELS-1:0] out,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic [CHANNELS-1:0] busy
);

  localparam int unsigned CW = ($clog2(STABLE_SAMPLES) > 1) ? $clog2(STABLE_SAMPLES) : 1;
  localparam logic [CW-1:0] CntLast = CW'(STABLE_SAMPLES - 1);

  logic [CHANNELS-1:0] sync_q [SYNC_STAGES];
  logic [CW-1:0]       cnt_q  [CHANNELS];
  logic [CHANNELS-1:0] out_q;
  logic [CHANNELS-1:0] rise_q;
  logic [CHANNELS-1:0] fall_q;
  logic [CHANNELS-1:0] sync_s;

  assign sync_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= RESET_LEVEL;
      end
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_q[i] <= '0;
      end
      out_q  <= RESET_LEVEL;
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      // The synchroniser shifts every cycle; only the debounce logic honours sample_en.
      sync_q[0] <= in;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_q[k-1];
      end
      rise_q <= '0;
      fall_q <= '0;
      if (sample_en) begin
        for (int i = 0; i < CHANNELS; i++) begin
          if (sync_s[i] == out_q[i]) begin
            cnt_q[i] <= '0;
          end else if (cnt_q[i] == CntLast) begin
            out_q[i]  <= sync_s[i];
            cnt_q[i]  <= '0;
            rise_q[i] <= sync_s[i];
            fall_q[i] <= ~sync_s[i];
          end else begin
            cnt_q[i] <= cnt_q[i] + CW'(1);
          end
        end
      end
    end
  end

  always_comb begin
    busy = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      busy[i] = (cnt_q[i] != '0);
    end
  end

  assign out  = out_q;
  assign rise = rise_q;
  assign fall = fall_q;

endmodule

// File: tb/tb_debouncer_bank.sv
// Bench for debouncer_bank: directed scenarios plus random bounce, checked against a
// sliding-window reference model (accept when the last N enabled samples all disagree).
module tb_debouncer_bank;
  localparam int CH = 4;
  localparam int N = 8;
  localparam int SYNC = 2;
  localparam logic [3:0] RL = 4'b0100;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sample_en = 1'b1;
  logic [3:0] in = RL;
  logic [3:0] out, rise, fall, busy;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  debouncer_bank #(
    .CHANNELS      (CH),
    .STABLE_SAMPLES(N),
    .SYNC_STAGES   (SYNC),
    .RESET_LEVEL   (RL)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in       (in),
    .sample_en(sample_en),
    .out      (out),
    .rise     (rise),
    .fall     (fall),
    .busy     (busy)
  );

  // Reference model: in is seen SYNC edges late; each channel keeps a window of its
  // most recent enabled samples and flips once N consecutive ones disagree with out.
  bit [3:0]   exp_out, exp_rise, exp_fall, exp_busy;
  bit [3:0]   pipe_q[$];
  bit [N-1:0] win [CH];
  int         nseen [CH];

  task automatic model_edge();
    bit [3:0] s;
    if (reset) begin
      pipe_q.delete();
      repeat (SYNC) pipe_q.push_back(RL);
      exp_out  = RL;
      exp_rise = '0;
      exp_fall = '0;
      exp_busy = '0;
      for (int c = 0; c < CH; c++) begin
        win[c]   = '0;
        nseen[c] = 0;
      end
    end else begin
      s = pipe_q.pop_front();
      pipe_q.push_back(in);
      exp_rise = '0;
      exp_fall = '0;
      if (sample_en) begin
        for (int c = 0; c < CH; c++) begin
          win[c] = {win[c][N-2:0], s[c]};
          if (nseen[c] < N) nseen[c]++;
          if (nseen[c] >= N && win[c] == {N{~exp_out[c]}}) begin
            exp_out[c] = ~exp_out[c];
            if (exp_out[c]) exp_rise[c] = 1'b1;
            else exp_fall[c] = 1'b1;
            nseen[c] = 0;
          end
          exp_busy[c] = (nseen[c] > 0) && (win[c][0] != exp_out[c]);
        end
      end
    end
  endtask

  // Advance one edge, update the model, then settle past the edge for sampling.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    in = RL;
    sample_en = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    in = 4'b1011;
    step();
    step();
    n_checks++;
    if ({out, rise, fall, busy} !== {RL, 4'b0, 4'b0, 4'b0}) begin
      n_fail++;
      $display("FAIL reset_state: got out=%b rise=%b fall=%b busy=%b, want %b 0000 0000 0000",
               out, rise, fall, busy, RL);
    end
    reset = 1'b0;
    for (int k = 0; k < 11; k++) begin
      step();
      n_checks++;
      if ({out, rise, fall, busy} !== {exp_out, exp_rise, exp_fall, exp_busy}) begin
        n_fail++;
        $display("FAIL reset_release edge %0d: got %b/%b/%b/%b want %b/%b/%b/%b", k,
                 out, rise, fall, busy, exp_out, exp_rise, exp_fall, exp_busy);
      end
      n_checks++;
      if (k < 9 && out !== RL) begin
        n_fail++;
        $display("FAIL reset_early edge %0d: out=%b want %b", k, out, RL);
      end else if (k == 9 && {out, rise, fall} !== {4'b1011, 4'b1011, 4'b0100}) begin
        n_fail++;
        $display("FAIL reset_edge9: out=%b rise=%b fall=%b want 1011 1011 0100",
                 out, rise, fall);
      end
    end
  endtask

  task automatic test_clean_step();
    do_reset();
    in = 4'b0101;
    for (int k = 0; k < 12; k++) begin
      step();
      n_checks++;
      if ({out, rise, fall, busy} !== {exp_out, exp_rise, exp_fall, exp_busy}) begin
        n_fail++;
        $display("FAIL clean_step edge %0d: got %b/%b/%b/%b want %b/%b/%b/%b", k,
                 out, rise, fall, busy, exp_out, exp_rise, exp_fall, exp_busy);
      end
      n_checks++;
      if (out[0] !== (k >= 9) || rise[0] !== (k == 9) || fall !== 4'b0 ||
          busy[0] !== (k >= 2 && k <= 8)) begin
        n_fail++;
        $display("FAIL clean_step_ch0 edge %0d: out0=%b rise0=%b fall=%b busy0=%b", k,
                 out[0], rise[0], fall, busy[0]);
      end
    end
  endtask

  task automatic test_bounce();
    int pattern [4] = '{6, 1, 5, 8};
    bit lvl;
    do_reset();
    lvl = 1'b1;
    for (int p = 0; p < 4; p++) begin
      for (int k = 0; k < pattern[p]; k++) begin
        in[1] = lvl;
        step();
        n_checks++;
        if ({out, rise, fall, busy} !== {exp_out, exp_rise, exp_fall, exp_busy} ||
            out[1] !== 1'b0 || rise[1] !== 1'b0) begin
          n_fail++;
          $display("FAIL bounce phase %0d: got %b/%b/%b/%b want %b/%b/%b/%b", p,
                   out, rise, fall, busy, exp_out, exp_rise, exp_fall, exp_busy);
        end
      end
      lvl = ~lvl;
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    in = 4'b0010;
    for (int k = 0; k < 12; k++) begin
      step();
      n_checks++;
      if ({out, rise, fall, busy} !== {exp_out, exp_rise, exp_fall, exp_busy}) begin
        n_fail++;
        $display("FAIL simultaneous edge %0d: got %b/%b/%b/%b want %b/%b/%b/%b", k,
                 out, rise, fall, busy, exp_out, exp_rise, exp_fall, exp_busy);
      end
      if (k == 9) begin
        n_checks++;
        if ({out, rise, fall} !== {4'b0010, 4'b0010, 4'b0100}) begin
          n_fail++;
          $display("FAIL simultaneous_edge9: out=%b rise=%b fall=%b want 0010 0010 0100",
                   out, rise, fall);
        end
      end
    end
  endtask

  task automatic test_gated();
    int pulses;
    do_reset();
    pulses = 0;
    in = 4'b1100;
    for (int k = 0; k < 40; k++) begin
      sample_en = (k % 4 == 0);
      step();
      n_checks++;
      if ({out, rise, fall, busy} !== {exp_out, exp_rise, exp_fall, exp_busy} ||
          (!sample_en && (rise | fall) !== 4'b0)) begin
        n_fail++;
        $display("FAIL gated edge %0d en=%b: got %b/%b/%b/%b want %b/%b/%b/%b", k, sample_en,
                 out, rise, fall, busy, exp_out, exp_rise, exp_fall, exp_busy);
      end
      if (rise[3]) pulses++;
      if (k == 31) begin
        n_checks++;
        if (out[3] !== 1'b0) begin
          n_fail++;
          $display("FAIL gated_early: out3=%b want 0 before 8th enabled edge", out[3]);
        end
      end
    end
    n_checks++;
    if (pulses != 1 || out[3] !== 1'b1) begin
      n_fail++;
      $display("FAIL gated_total: pulses=%0d out3=%b want 1 1", pulses, out[3]);
    end
    sample_en = 1'b1;
  endtask

  task automatic test_reset_mid();
    do_reset();
    in = 4'b0101;
    repeat (7) step();
    reset = 1'b1;
    step();
    n_checks++;
    if ({out, busy} !== {RL, 4'b0}) begin
      n_fail++;
      $display("FAIL reset_mid_state: out=%b busy=%b want %b 0000", out, busy, RL);
    end
    reset = 1'b0;
    for (int k = 0; k < 12; k++) begin
      step();
      n_checks++;
      if ({out, rise, fall, busy} !== {exp_out, exp_rise, exp_fall, exp_busy} ||
          out[0] !== (k >= 9)) begin
        n_fail++;
        $display("FAIL reset_mid edge %0d: got %b/%b/%b/%b want %b/%b/%b/%b", k,
                 out, rise, fall, busy, exp_out, exp_rise, exp_fall, exp_busy);
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 600; k++) begin
      for (int c = 0; c < CH; c++) begin
        if ($urandom_range(0, 11) == 0) in[c] = ~in[c];
      end
      sample_en = ($urandom_range(0, 3) != 0);
      reset = ($urandom_range(0, 249) == 0);
      step();
      n_checks++;
      if ({out, rise, fall, busy} !== {exp_out, exp_rise, exp_fall, exp_busy}) begin
        n_fail++;
        $display("FAIL random cycle %0d: got %b/%b/%b/%b want %b/%b/%b/%b", k,
                 out, rise, fall, busy, exp_out, exp_rise, exp_fall, exp_busy);
      end
    end
    reset = 1'b0;
    sample_en = 1'b1;
  endtask

  initial begin
    test_reset();
    test_clean_step();
    test_bounce();
    test_simultaneous();
    test_gated();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
